// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: scan-out reads have strict priority, CPU writes drain from a small FIFO.
// Optional CPU read-back path enabled by defining FB_READBACK_EN.
`timescale 1ns/1ps
module fb_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [LVL_W-1:0]  fifo_level,
`ifdef FB_READBACK_EN
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_valid,
    output logic [DATA_W-1:0] cpu_rd_data,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg, level_next;
    logic               ready_en_reg;
    logic               fifo_full, fifo_empty, push, pop;
    logic               rd_grant, rd_block;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ENTRY_W-1:0] head;

    logic               ram_en_reg, ram_we_reg;
    logic [ADDR_W-1:0]  ram_addr_reg;
    logic [DATA_W-1:0]  ram_wdata_reg;
    logic               scan_p1_reg, scan_p2_reg, scan_valid_reg;
    logic [DATA_W-1:0]  scan_data_reg;

    assign fifo_full    = (level_reg == LVL_W'(FIFO_DEPTH));
    assign fifo_empty   = (level_reg == '0);
    assign cpu_wr_ready = ready_en_reg && !fifo_full && !rd_block;
    assign push         = cpu_wr_valid && cpu_wr_ready;
    // The level seen here excludes this cycle's push, so a new entry pops one cycle later at the earliest.
    assign pop          = !fifo_empty && !scan_req && !rd_grant;
    assign head         = fifo_mem[rd_ptr_reg];
    assign fifo_level   = level_reg;

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = level_reg - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cpu_wr_addr, cpu_wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            level_reg    <= level_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    // One RAM access per cycle; address and write data hold when the port is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            scan_p1_reg    <= 1'b0;
            scan_p2_reg    <= 1'b0;
            scan_valid_reg <= 1'b0;
            scan_data_reg  <= '0;
        end else begin
            scan_p1_reg    <= scan_req;
            scan_p2_reg    <= scan_p1_reg;
            scan_valid_reg <= scan_p2_reg;
            if (scan_p2_reg) scan_data_reg <= ram_rdata;
            if (scan_req) begin
                ram_en_reg   <= 1'b1;
                ram_we_reg   <= 1'b0;
                ram_addr_reg <= scan_addr;
            end else if (rd_grant) begin
                ram_en_reg   <= 1'b1;
                ram_we_reg   <= 1'b0;
                ram_addr_reg <= rd_addr;
            end else if (pop) begin
                ram_en_reg    <= 1'b1;
                ram_we_reg    <= 1'b1;
                ram_addr_reg  <= head[ENTRY_W-1:DATA_W];
                ram_wdata_reg <= head[DATA_W-1:0];
            end else begin
                ram_en_reg <= 1'b0;
                ram_we_reg <= 1'b0;
            end
        end
    end

    assign ram_en     = ram_en_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign scan_valid = scan_valid_reg;
    assign scan_data  = scan_data_reg;

`ifdef FB_READBACK_EN
    typedef enum logic [2:0] {RD_IDLE, RD_DRAIN, RD_ISSUE, RD_WAIT, RD_DONE} rd_state_t;
    rd_state_t         rd_state_reg, rd_state_next;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              cpu_rd_valid_reg;
    logic [DATA_W-1:0] cpu_rd_data_reg;

    assign rd_block = (rd_state_reg != RD_IDLE);
    assign rd_grant = (rd_state_reg == RD_ISSUE) && !scan_req;
    assign rd_addr  = rd_addr_reg;

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            RD_IDLE:  if (cpu_rd_req) rd_state_next = RD_DRAIN;
            // Wait out queued writes and the write on the port so the read sees the newest pixel.
            RD_DRAIN: if (fifo_empty && !(ram_en_reg && ram_we_reg)) rd_state_next = RD_ISSUE;
            RD_ISSUE: if (rd_grant) rd_state_next = RD_WAIT;
            RD_WAIT:  rd_state_next = RD_DONE;
            RD_DONE:  rd_state_next = RD_IDLE;
            default:  rd_state_next = RD_IDLE;
        endcase
    end

    // Read data is valid on ram_rdata during RD_DONE and is registered onto the CPU port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_reg     <= RD_IDLE;
            rd_addr_reg      <= '0;
            cpu_rd_valid_reg <= 1'b0;
            cpu_rd_data_reg  <= '0;
        end else begin
            rd_state_reg     <= rd_state_next;
            cpu_rd_valid_reg <= (rd_state_reg == RD_DONE);
            if (rd_state_reg == RD_IDLE && cpu_rd_req) rd_addr_reg <= cpu_rd_addr;
            if (rd_state_reg == RD_DONE) cpu_rd_data_reg <= ram_rdata;
        end
    end

    assign cpu_rd_valid = cpu_rd_valid_reg;
    assign cpu_rd_data  = cpu_rd_data_reg;
`else
    assign rd_block = 1'b0;
    assign rd_grant = 1'b0;
    assign rd_addr  = '0;
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: RAM model plus scoreboard queues for scan reads and CPU writes.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
    localparam int AW = 15;
    localparam int DW = 12;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          cpu_wr_valid;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic [LW-1:0] fifo_level;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef FB_READBACK_EN
    logic          cpu_rd_req;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_rd_valid;
    logic [DW-1:0] cpu_rd_data;
    bit            rb_pending;
`endif

    always #5 clk = ~clk;

    fb_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .fifo_level(fifo_level),
`ifdef FB_READBACK_EN
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
`endif
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Background image: unwritten locations return a known pattern; 0x0123 holds 0xF0F.
    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        logic [31:0] t;
        if (a == 15'h0123) return 12'hF0F;
        t = 32'(a) * 7 + 3;
        return t[DW-1:0];
    endfunction

    logic [DW-1:0] mem   [1 << AW];
    bit            wmask [1 << AW];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]   <= ram_wdata;
                wmask[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= wmask[ram_addr] ? mem[ram_addr] : pix(ram_addr);
            end
        end
    end

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t rq[$], sq[$], wq[$], send_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   max_level = 0;
    bit   ready_low_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        bit   got_rd, exp_rd, exp_sv;
        exp_t e;
        got_rd = (ram_en === 1'b1) && (ram_we === 1'b0);
        exp_rd = (rq.size() > 0) && (rq[0].due == cyc);
`ifdef FB_READBACK_EN
        if (got_rd && !exp_rd && rb_pending && ram_addr == 15'h0042) begin
            rb_pending = 0;
            got_rd = 0;
        end
`endif
        if (got_rd || exp_rd) begin
            chk("scan_rd_issue", 32'(got_rd), 32'(exp_rd));
            if (got_rd && exp_rd) chk("scan_rd_addr", 32'(ram_addr), 32'(rq[0].addr));
            if (exp_rd) void'(rq.pop_front());
        end
        if (ram_en === 1'b1 && ram_we === 1'b1) begin
            chk("wr_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.addr));
                chk("wr_data", 32'(ram_wdata), 32'(e.data));
            end
        end
        exp_sv = (sq.size() > 0) && (sq[0].due == cyc);
        if (scan_valid !== 1'b0 || exp_sv) begin
            chk("scan_valid", 32'(scan_valid), 32'(exp_sv));
            if (exp_sv) begin
                e = sq.pop_front();
                chk("scan_data", 32'(scan_data), 32'(e.data));
            end
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (reset_n && !cpu_wr_ready) ready_low_seen = 1;
    endtask

    // Advance one cycle: record accepted writes, clock, check outputs, then drive next inputs.
    task automatic tick();
        if (cpu_wr_valid && cpu_wr_ready && send_q.size() > 0) wq.push_back(send_q.pop_front());
        @(posedge clk);
        cyc++;
        #1;
        monitor();
        scan_req = 1'b0;
`ifdef FB_READBACK_EN
        cpu_rd_req = 1'b0;
`endif
        cpu_wr_valid = (send_q.size() > 0) && reset_n;
        if (send_q.size() > 0) begin
            cpu_wr_addr = send_q[0].addr;
            cpu_wr_data = send_q[0].data;
        end
    endtask

    task automatic do_scan(input logic [AW-1:0] a);
        scan_req  = 1'b1;
        scan_addr = a;
        rq.push_back('{cyc + 1, a, '0});
        sq.push_back('{cyc + 3, a, pix(a)});
    endtask

    task automatic queue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_q.push_back('{0, a, d});
    endtask

    initial begin
        bit found;
        reset_n      = 1'b0;
        scan_req     = 1'b0;
        scan_addr    = '0;
        cpu_wr_valid = 1'b0;
        cpu_wr_addr  = '0;
        cpu_wr_data  = '0;
`ifdef FB_READBACK_EN
        cpu_rd_req  = 1'b0;
        cpu_rd_addr = '0;
        rb_pending  = 0;
`endif
        #1;
        chk("rst_ready", 32'(cpu_wr_ready), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("idle_ready", 32'(cpu_wr_ready), 32'd1);
        chk("idle_level", 32'(fifo_level), 32'd0);
        chk("idle_ram_en", 32'(ram_en), 32'd0);
        chk("idle_scan_valid", 32'(scan_valid), 32'd0);

        // Single scan at cycle 10 of address 0x0123.
        while (cyc < 10) tick();
        do_scan(15'h0123);
        repeat (5) tick();
        chk("scan1_done", 32'(sq.size()), 32'd0);

        // Five writes while scans hold the port every cycle: FIFO fills, then drains in order.
        for (int i = 1; i <= 5; i++) queue_write(AW'(i), DW'(i));
        max_level = 0;
        ready_low_seen = 0;
        for (int i = 0; i < 8; i++) begin
            do_scan(AW'(16'h0300 + i));
            tick();
        end
        repeat (12) tick();
        chk("burst_peak_level", 32'(max_level), 32'd4);
        chk("burst_ready_dropped", 32'(ready_low_seen), 32'd1);
        chk("burst_all_written", 32'(wq.size() + send_q.size()), 32'd0);
        chk("burst_scans_done", 32'(sq.size() + rq.size()), 32'd0);

        // Scan every second cycle against a continuous write stream.
        for (int i = 0; i < 16; i++) queue_write(AW'(16'h0200 + i), DW'(16'h0800 + i));
        max_level = 0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) do_scan(AW'(16'h0100 + i / 2));
            tick();
        end
        repeat (12) tick();
        chk("mixed_level_bound", 32'(max_level <= 4), 32'd1);
        chk("mixed_all_written", 32'(wq.size() + send_q.size()), 32'd0);
        chk("mixed_scans_done", 32'(sq.size() + rq.size()), 32'd0);

        // Reset mid-stream with queued writes and a scan in flight.
        for (int i = 0; i < 8; i++) queue_write(AW'(16'h0400 + i), DW'(16'h0A00 + i));
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i % 2 == 0) do_scan(AW'(16'h0500 + i));
            tick();
            if (fifo_level == 3 && sq.size() > 0) found = 1;
        end
        chk("pre_reset_state", 32'(found), 32'd1);
        reset_n      = 1'b0;
        cpu_wr_valid = 1'b0;
        scan_req     = 1'b0;
        #1;
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_ram_en", 32'(ram_en), 32'd0);
        chk("arst_ram_we", 32'(ram_we), 32'd0);
        chk("arst_ready", 32'(cpu_wr_ready), 32'd0);
        chk("arst_scan_valid", 32'(scan_valid), 32'd0);
        send_q.delete();
        wq.delete();
        rq.delete();
        sq.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cpu_wr_ready), 32'd1);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        repeat (5) tick();

`ifdef FB_READBACK_EN
        queue_write(15'h0042, 12'hABC);
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 15'h0042;
        cpu_wr_data  = 12'hABC;
        cpu_rd_req   = 1'b1;
        cpu_rd_addr  = 15'h0042;
        rb_pending   = 1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (cpu_rd_valid) begin
                found = 1;
                chk("rb_data", 32'(cpu_rd_data), 32'h0ABC);
            end
        end
        chk("rb_returned", 32'(found), 32'd1);
        chk("rb_write_drained", 32'(wq.size() + send_q.size()), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
